// File: rtl/waveform_pkg.sv
// Shared types and constants for the waveform converter controller.
// Holds select encodings, the one-hot check and the controller state enum.
package waveform_pkg;

    localparam int unsigned DEF_N_SAMPLES = 256;
    localparam int unsigned DEF_DATA_W    = 8;
    localparam int unsigned DEF_TIMEOUT   = 64;
    localparam int unsigned SEL_W         = 4;

    localparam logic [SEL_W-1:0] SEL_SINE   = 4'b0001;
    localparam logic [SEL_W-1:0] SEL_TRI    = 4'b0010;
    localparam logic [SEL_W-1:0] SEL_SQUARE = 4'b0100;
    localparam logic [SEL_W-1:0] SEL_FM     = 4'b1000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        START  = 2'd1,
        WAIT   = 2'd2,
        STREAM = 2'd3
    } ctrl_state_e;

    // True when exactly one select bit is set.
    function automatic logic is_onehot(input logic [SEL_W-1:0] sel);
        return (sel != '0) && ((sel & (sel - SEL_W'(1))) == '0);
    endfunction

endpackage

// File: rtl/waveform_if.sv
// Valid/ready sample stream from the waveform controller toward the filter.
interface waveform_if
    import waveform_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W
) ();

    logic [DATA_W-1:0] sample_out;
    logic              sample_valid;
    logic              sample_ready;
    logic              sample_last;

    modport master (
        output sample_out,
        output sample_valid,
        output sample_last,
        input  sample_ready
    );

    modport slave (
        input  sample_out,
        input  sample_valid,
        input  sample_last,
        output sample_ready
    );

endinterface

// File: rtl/waveform_ctrl.sv
// Sequences the waveform converter (select, start, ready wait) and streams
// the converted frame out, optionally replaying it in loop mode.
module waveform_ctrl
    import waveform_pkg::*;
#(
    parameter int unsigned N_SAMPLES = DEF_N_SAMPLES,
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned TIMEOUT   = DEF_TIMEOUT
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [SEL_W-1:0]              sw,
    input  logic                          go,
    input  logic                          stop,
    input  logic                          loop,
    output logic [SEL_W-1:0]              conv_sel,
    output logic                          conv_start,
    input  logic                          conv_rdy,
    output logic [$clog2(N_SAMPLES)-1:0]  rd_addr,
    input  logic [DATA_W-1:0]             rd_data,
    output logic                          busy,
    output logic                          sel_err,
    output logic                          tmo_err,
    waveform_if.master                    strm
);

    localparam int unsigned AW = $clog2(N_SAMPLES);
    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    localparam logic [AW-1:0] LAST_IDX = AW'(N_SAMPLES - 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

    ctrl_state_e   state;
    logic [CW-1:0] wait_cnt;
    logic          hs_last;
    logic          reselect;

    assign hs_last  = strm.sample_valid && strm.sample_ready && strm.sample_last;
    assign reselect = is_onehot(sw) && (sw != conv_sel);

    // rd_addr doubles as the index of the next sample to load.
    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            wait_cnt          <= '0;
            conv_sel          <= SEL_SINE;
            conv_start        <= 1'b0;
            rd_addr           <= '0;
            busy              <= 1'b0;
            sel_err           <= 1'b0;
            tmo_err           <= 1'b0;
            strm.sample_out   <= '0;
            strm.sample_valid <= 1'b0;
            strm.sample_last  <= 1'b0;
        end else begin
            conv_start <= 1'b0;
            if (stop) begin
                state             <= IDLE;
                busy              <= 1'b0;
                rd_addr           <= '0;
                strm.sample_valid <= 1'b0;
                strm.sample_last  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (go) begin
                            if (is_onehot(sw)) begin
                                conv_sel   <= sw;
                                sel_err    <= 1'b0;
                                tmo_err    <= 1'b0;
                                conv_start <= 1'b1;
                                busy       <= 1'b1;
                                state      <= START;
                            end else begin
                                sel_err <= 1'b1;
                            end
                        end
                    end
                    START: begin
                        wait_cnt <= '0;
                        state    <= WAIT;
                    end
                    // First WAIT cycle ignores a ready left over from a prior conversion.
                    WAIT: begin
                        if ((wait_cnt != '0) && conv_rdy) begin
                            rd_addr <= '0;
                            state   <= STREAM;
                        end else if (wait_cnt == TMO_LAST) begin
                            tmo_err <= 1'b1;
                            busy    <= 1'b0;
                            state   <= IDLE;
                        end else if (wait_cnt != '1) begin
                            wait_cnt <= wait_cnt + CW'(1);
                        end
                    end
                    STREAM: begin
                        if (hs_last && !loop) begin
                            busy              <= 1'b0;
                            strm.sample_valid <= 1'b0;
                            strm.sample_last  <= 1'b0;
                            state             <= IDLE;
                        end else if (hs_last && reselect) begin
                            conv_sel          <= sw;
                            conv_start        <= 1'b1;
                            strm.sample_valid <= 1'b0;
                            strm.sample_last  <= 1'b0;
                            state             <= START;
                        end else if (!strm.sample_valid || strm.sample_ready) begin
                            strm.sample_out   <= rd_data;
                            strm.sample_valid <= 1'b1;
                            strm.sample_last  <= (rd_addr == LAST_IDX);
                            rd_addr           <= rd_addr + AW'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_waveform_ctrl.sv
// Self-checking bench for waveform_ctrl: directed scenarios plus a stream
// model that predicts every transferred sample from select, index and loop rules.
module tb_waveform_ctrl;
    import waveform_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] sw;
    logic       go, stop, loop, conv_rdy;
    logic [3:0] conv_sel;
    logic       conv_start;
    logic [7:0] rd_addr;
    logic [7:0] rd_data;
    logic       busy, sel_err, tmo_err;

    waveform_if #(.DATA_W(8)) strm ();

    always #5 clk = ~clk;

    // Converter frame content: a distinct ramp per waveform.
    function automatic logic [7:0] frame_val(input logic [3:0] s, input int idx);
        int m, o;
        case (s)
            4'b0001: begin m = 1; o = 0;   end
            4'b0010: begin m = 3; o = 17;  end
            4'b0100: begin m = 5; o = 34;  end
            4'b1000: begin m = 7; o = 51;  end
            default: begin m = 0; o = 238; end
        endcase
        return 8'((idx * m + o) % 256);
    endfunction

    assign rd_data = frame_val(conv_sel, int'(rd_addr));

    waveform_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .sw         (sw),
        .go         (go),
        .stop       (stop),
        .loop       (loop),
        .conv_sel   (conv_sel),
        .conv_start (conv_start),
        .conv_rdy   (conv_rdy),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .busy       (busy),
        .sel_err    (sel_err),
        .tmo_err    (tmo_err),
        .strm       (strm)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Stream model state
    logic [3:0] m_sel;
    int         m_idx, hs_count, fm_frames, phase;
    logic [7:0] first_data, last_data, prev_data;
    logic       prev_last, prev_hold, stop_prev, exp_end, exp_cont;

    always @(negedge clk) begin
        if (rst) begin
            prev_hold = 1'b0; stop_prev = 1'b0; exp_end = 1'b0; exp_cont = 1'b0; phase = 0;
        end else begin
            if (stop_prev) begin
                chk("stop_valid", 32'(strm.sample_valid), 32'd0);
                chk("stop_busy", 32'(busy), 32'd0);
            end
            if (exp_end) begin
                chk("end_busy", 32'(busy), 32'd0);
                chk("end_valid", 32'(strm.sample_valid), 32'd0);
                exp_end = 1'b0;
            end
            if (exp_cont) begin
                chk("wrap_no_bubble", 32'(strm.sample_valid), 32'd1);
                exp_cont = 1'b0;
            end
            if (phase != 0) begin
                if (phase == 1) begin
                    chk("reselect_start", 32'(conv_start), 32'd1);
                    chk("reselect_sel", 32'(conv_sel), 32'(m_sel));
                end
                chk("reselect_bubble", 32'(strm.sample_valid), 32'd0);
                phase = (phase == 4) ? 0 : phase + 1;
            end
            if (prev_hold) begin
                chk("hold_valid", 32'(strm.sample_valid), 32'd1);
                chk("hold_data", 32'(strm.sample_out), 32'(prev_data));
                chk("hold_last", 32'(strm.sample_last), 32'(prev_last));
            end
            if (strm.sample_valid && strm.sample_ready) begin
                chk("data", 32'(strm.sample_out), 32'(frame_val(m_sel, m_idx)));
                chk("last", 32'(strm.sample_last), 32'(m_idx == 255));
                if (m_idx == 0) first_data = strm.sample_out;
                last_data = strm.sample_out;
                hs_count++;
                if (m_idx == 255) begin
                    if (m_sel == 4'b1000) fm_frames++;
                    if (!stop) begin
                        if (!loop) exp_end = 1'b1;
                        else if ($countones(sw) == 1 && sw != m_sel) begin
                            m_sel = sw;
                            phase = 1;
                        end else exp_cont = 1'b1;
                    end
                end
                m_idx = (m_idx + 1) % 256;
            end
            prev_hold = strm.sample_valid && !strm.sample_ready && !stop;
            prev_data = strm.sample_out;
            prev_last = strm.sample_last;
            stop_prev = stop;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic cyc(input int n);
        repeat (n) tick();
    endtask

    // Pulse go for one edge; model restarts when the select is acceptable.
    task automatic do_go(input logic [3:0] s);
        tick();
        sw = s;
        go = 1'b1;
        @(posedge clk);
        #2;
        go = 1'b0;
        if ($countones(s) == 1) begin
            m_sel = s; m_idx = 0; hs_count = 0;
        end
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(busy), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, n;
        logic seen;
        rst = 1'b1; go = 1'b0; stop = 1'b0; loop = 1'b0; sw = 4'b0001;
        conv_rdy = 1'b1; strm.sample_ready = 1'b1;
        m_sel = 4'b0001; m_idx = 0; hs_count = 0; fm_frames = 0;
        first_data = '0; last_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_conv_sel", 32'(conv_sel), 32'h1);
        chk("rst_conv_start", 32'(conv_start), 32'd0);
        chk("rst_rd_addr", 32'(rd_addr), 32'd0);
        chk("rst_sample_out", 32'(strm.sample_out), 32'd0);
        chk("rst_valid", 32'(strm.sample_valid), 32'd0);
        chk("rst_last", 32'(strm.sample_last), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_errs", 32'({sel_err, tmo_err}), 32'd0);
        tick();
        rst = 1'b0;
        cyc(2);

        // Single square frame, ready held high
        do_go(4'b0100);
        @(negedge clk);
        chk("go_conv_start", 32'(conv_start), 32'd1);
        chk("go_conv_sel", 32'(conv_sel), 32'h4);
        chk("go_busy", 32'(busy), 32'd1);
        @(negedge clk);
        chk("start_single", 32'(conv_start), 32'd0);
        k = 1;
        while (!strm.sample_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("first_valid_lat", 32'(k), 32'd4);
        wait_idle(600, "sq_done");
        chk("sq_count", 32'(hs_count), 32'd256);
        chk("sq_first", 32'(first_data), 32'h22);
        chk("sq_last", 32'(last_data), 32'h1D);

        // Invalid selects, then a valid one clears sel_err
        do_go(4'b0011);
        @(negedge clk);
        chk("bad_sel_err", 32'(sel_err), 32'd1);
        chk("bad_busy", 32'(busy), 32'd0);
        chk("bad_no_start", 32'(conv_start), 32'd0);
        chk("bad_sel_keep", 32'(conv_sel), 32'h4);
        do_go(4'b0000);
        @(negedge clk);
        chk("zero_sel_err", 32'(sel_err), 32'd1);
        chk("zero_busy", 32'(busy), 32'd0);
        do_go(4'b0001);
        @(negedge clk);
        chk("good_sel_clr", 32'(sel_err), 32'd0);
        chk("good_start", 32'(conv_start), 32'd1);
        wait_idle(600, "sine_done");
        chk("sine_count", 32'(hs_count), 32'd256);
        chk("sine_last", 32'(last_data), 32'hFF);

        // Converter never ready: timeout after 64 WAIT cycles
        conv_rdy = 1'b0;
        do_go(4'b0010);
        seen = 1'b0;
        for (int i = 0; i <= 65; i++) begin
            @(negedge clk);
            if (strm.sample_valid) seen = 1'b1;
            if (i == 64) begin
                chk("tmo_pre_busy", 32'(busy), 32'd1);
                chk("tmo_pre_err", 32'(tmo_err), 32'd0);
            end
            if (i == 65) begin
                chk("tmo_err", 32'(tmo_err), 32'd1);
                chk("tmo_busy", 32'(busy), 32'd0);
            end
        end
        chk("tmo_no_valid", 32'(seen), 32'd0);
        conv_rdy = 1'b1;
        do_go(4'b0010);
        @(negedge clk);
        chk("tmo_cleared", 32'(tmo_err), 32'd0);
        wait_idle(600, "tri_done");
        chk("tri_count", 32'(hs_count), 32'd256);

        // Random back-pressure
        do_go(4'b0001);
        n = 0;
        while (busy && n < 3000) begin
            tick();
            strm.sample_ready = 1'($urandom_range(0, 1));
            n++;
        end
        strm.sample_ready = 1'b1;
        chk("bp_done", 32'(busy), 32'd0);
        chk("bp_count", 32'(hs_count), 32'd256);

        // Loop mode: wrap, reselect to FM, then ignore an invalid select
        loop = 1'b1;
        fm_frames = 0;
        do_go(4'b0001);
        cyc(300);
        sw = 4'b1000;
        n = 0;
        while (fm_frames < 1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("loop_fm_frame", 32'(fm_frames >= 1), 32'd1);
        chk("fm_first", 32'(first_data), 32'h33);
        chk("fm_last", 32'(last_data), 32'h2C);
        tick();
        sw = 4'b0011;
        n = 0;
        while (fm_frames < 2 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("loop_invalid_wrap", 32'(fm_frames >= 2), 32'd1);
        chk("loop_sel_kept", 32'(conv_sel), 32'h8);
        tick();
        stop = 1'b1;
        loop = 1'b0;
        tick();
        stop = 1'b0;
        cyc(2);
        chk("loop_stopped", 32'(busy), 32'd0);

        // Stop mid-frame, then stop beats a simultaneous go, then restart
        do_go(4'b0100);
        n = 0;
        while (hs_count < 100 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("stop_reach_100", 32'(hs_count >= 100), 32'd1);
        tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tick();
        sw = 4'b0001;
        go = 1'b1;
        stop = 1'b1;
        @(posedge clk);
        #2;
        go = 1'b0;
        stop = 1'b0;
        @(negedge clk);
        chk("stopgo_busy", 32'(busy), 32'd0);
        chk("stopgo_no_start", 32'(conv_start), 32'd0);
        chk("stopgo_sel_keep", 32'(conv_sel), 32'h4);
        do_go(4'b0001);
        wait_idle(600, "restart_done");
        chk("restart_count", 32'(hs_count), 32'd256);
        chk("restart_first", 32'(first_data), 32'h00);

        cyc(3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/waveform_ctrl.md
# waveform_ctrl

Controller that sequences the 256-sample waveform converter and streams its result downstream. It latches and validates the one-hot waveform select, pulses the converter's start for one cycle, and waits for its ready with a timeout. It then reads the converted frame sample by sample over an address/data port and delivers it on a valid/ready stream toward the digital filter. In loop mode it replays the frame continuously and reconverts at a frame boundary when the select changes.

## Interface
- N_SAMPLES, 256: frame length; power of two.
- DATA_W, 8: sample width.
- TIMEOUT, 64: max cycles waited for converter ready.
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- sw  in  4  requested waveform, one-hot: 0001 sine, 0010 triangle, 0100 square, 1000 FM.
- go  in  1  start request pulse.
- stop  in  1  abort request.
- loop  in  1  replay frame continuously.
- conv_sel  out  4  registered select to converter.
- conv_start  out  1  one-cycle start pulse to converter.
- conv_rdy  in  1  converter ready. Level signal; stays high after its first completion.
- rd_addr  out  log2(N_SAMPLES)  converter output sample index.
- rd_data  in  DATA_W  sample at rd_addr, combinational, same cycle.
- sample_out  out  DATA_W  stream data.
- sample_valid  out  1  stream valid.
- sample_ready  in  1  downstream ready.
- sample_last  out  1  high with index N_SAMPLES-1.
- busy  out  1  state ≠ IDLE.
- sel_err  out  1  sticky: invalid select on go.
- tmo_err  out  1  sticky: converter timeout.

## Operation
- States: IDLE, START, WAIT, STREAM.
- IDLE:
  - On go with sw one-hot: latch conv_sel=sw, clear both error flags, go to START.
  - On go with sw not one-hot (0000 or ≥2 bits): set sel_err, stay in IDLE.
  - go is ignored in every other state.
- START: conv_start=1 for exactly this cycle; go to WAIT; wait counter cleared.
- WAIT:
  - conv_rdy is ignored on the first WAIT cycle, because it may still be high from a prior conversion.
  - From the second WAIT cycle on, conv_rdy=1 sends the FSM to STREAM with index 0.
  - If TIMEOUT cycles elapse with no qualifying ready: set tmo_err, go to IDLE.
- STREAM:
  - Output register loads rd_data when !sample_valid || sample_ready; rd_addr = index being loaded.
  - Index increments on each load.
  - sample_valid is held with sample_out stable until a handshake.
  - Handshake on the last sample:
    - loop=0: go to IDLE.
    - loop=1, sw unchanged: wrap the index to 0 and continue with no bubble.
    - loop=1, sw a different valid one-hot: latch the new select, go to START (reconvert).
    - loop=1, sw invalid: keep the old select and wrap.
- stop has priority in all states. Next cycle: state IDLE, sample_valid=0 (frame abandoned mid-stream), conv_start=0. Error flags keep their values.
- Simultaneous go and stop in IDLE: stop wins, nothing latched.
- Index arithmetic is modulo N_SAMPLES; the wait counter saturates.

## Timing
- Reset values:
  - state IDLE.
  - conv_sel=0001, conv_start=0.
  - rd_addr=0.
  - sample_out=0, sample_valid=0, sample_last=0.
  - busy=0, sel_err=0, tmo_err=0.
- Cycle numbering from go accepted at edge E:
  - START at E+1: conv_start high during E+1..E+2.
  - WAIT from E+2; earliest ready qualification at E+3.
  - First sample_valid at E+5, given conv_rdy already high.
- Throughput 1 sample/cycle with sample_ready held high. Continuous across a loop wrap; a reselect costs 4+ bubble cycles.
- busy drops the cycle after the final handshake, stop, or timeout.
- conv_sel is stable for the whole START..STREAM span; it changes only in IDLE or at a reselect boundary.

## Structure
- Shared package waveform_pkg holds:
  - sel constants SEL_SINE, SEL_TRI, SEL_SQUARE, SEL_FM;
  - the one-hot check function;
  - the ctrl state enum;
  - default N_SAMPLES and DATA_W.
- No sub-module: FSM, index counter, wait counter and output register live in one module.

## Test plan
- go with sw=0100, conv_rdy=1, ready=1 -> conv_start single pulse at E+1; 256 samples equal to the model frame at indices 0..255; sample_last on the 256th; busy low after.
- go with sw=0011 -> sel_err=1, busy stays 0, no conv_start; later go with sw=0001 clears sel_err and runs.
- conv_rdy held 0 -> tmo_err=1 after 64 WAIT cycles, state IDLE, no sample_valid.
- Random sample_ready back-pressure -> sample_out held while valid && !ready; no sample lost or duplicated; order 0..255.
- loop=1, sw switched 0001->1000 mid-frame -> current frame completes with sine data, then conv_start pulse with conv_sel=1000, and the next frame streams FM data.
- stop asserted at sample 100 -> sample_valid=0 next cycle, IDLE; a following go restarts from index 0.
